// File: rtl/mult_share_pkg.sv
// Shared constants and types for the multiplier-sharing scheduler.
// Defaults, channel-tag width helper and the per-channel state encoding.
package mult_share_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DW       = 16;
    localparam int DEF_MULT_LAT = 2;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_PEND   = 2'd1,
        CH_FLIGHT = 2'd2
    } ch_state_e;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_TAG_W = tag_width(DEF_NUM_CH);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr,
// then moves rr_ptr one past the winner.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TAG_W  = tag_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_oh_o,
    output logic [TAG_W-1:0]  gnt_idx_o,
    output logic              gnt_vld_o
);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    int               idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        gnt_oh_o  = '0;
        idx       = 0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CH;
            if (en_i && req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = TAG_W'(idx);
            end
        end
        if (gnt_vld_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld_o) begin
            rr_ptr_d = (int'(gnt_idx_o) == NUM_CH - 1) ? '0 : TAG_W'(int'(gnt_idx_o) + 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one pipelined multiplier among NUM_CH register-mapped channels:
// latches operands, issues round-robin, routes tagged products back.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DW       = DEF_DW,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    input  logic                   enable_i,
    input  logic [NUM_CH-1:0]      req_i,
    input  logic [NUM_CH*DW-1:0]   a_i,
    input  logic [NUM_CH*DW-1:0]   b_i,
    input  logic [NUM_CH-1:0]      clr_i,
    output logic [DW-1:0]          mult_a_o,
    output logic [DW-1:0]          mult_b_o,
    output logic                   mult_issue_o,
    input  logic [2*DW-1:0]        mult_c_i,
    output logic [NUM_CH*2*DW-1:0] c_o,
    output logic [NUM_CH-1:0]      valid_o,
    output logic [NUM_CH-1:0]      done_o,
    output logic [NUM_CH-1:0]      err_o,
    output logic                   busy_o
);

    localparam int TAG_W = tag_width(NUM_CH);
    localparam int PW    = 2 * DW;

    ch_state_e                 state_q [NUM_CH];
    ch_state_e                 state_d [NUM_CH];
    logic [NUM_CH*DW-1:0]      a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]          tag_q [MULT_LAT];
    logic [TAG_W-1:0]          tag_d [MULT_LAT];
    logic [MULT_LAT-1:0]       vld_q, vld_d;
    logic [NUM_CH*PW-1:0]      c_q, c_d;
    logic [NUM_CH-1:0]         valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic                      busy_q, busy_d;

    logic [NUM_CH-1:0]         pend;
    logic [NUM_CH-1:0]         gnt_oh;
    logic [TAG_W-1:0]          gnt_idx;
    logic                      gnt_vld;
    logic                      res_vld;
    logic [TAG_W-1:0]          res_tag;

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            pend[n] = (state_q[n] == CH_PEND);
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) u_arb (
        .clk_i     (WBs_CLK_i),
        .rst_n_i   (WBs_RST_i),
        .en_i      (enable_i),
        .req_i     (pend),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign mult_issue_o = gnt_vld;
    assign mult_a_o     = gnt_vld ? a_q[int'(gnt_idx)*DW +: DW] : '0;
    assign mult_b_o     = gnt_vld ? b_q[int'(gnt_idx)*DW +: DW] : '0;

    // The tag pipeline output lines up with the product on mult_c_i.
    assign res_vld = vld_q[MULT_LAT-1];
    assign res_tag = tag_q[MULT_LAT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = '0;

        for (int n = 0; n < NUM_CH; n++) begin
            case (state_q[n])
                CH_IDLE: begin
                    if (req_i[n]) begin
                        state_d[n]       = CH_PEND;
                        a_d[n*DW +: DW] = a_i[n*DW +: DW];
                        b_d[n*DW +: DW] = b_i[n*DW +: DW];
                    end
                end
                CH_PEND: begin
                    if (gnt_oh[n]) state_d[n] = CH_FLIGHT;
                end
                CH_FLIGHT: begin
                    if (res_vld && int'(res_tag) == n) state_d[n] = CH_IDLE;
                end
                default: state_d[n] = CH_IDLE;
            endcase

            if (clr_i[n]) begin
                valid_d[n] = 1'b0;
                err_d[n]   = 1'b0;
            end
            if (req_i[n] && state_q[n] != CH_IDLE) begin
                err_d[n] = 1'b1;
            end
            // A result write overrides a same-cycle clear of valid.
            if (res_vld && int'(res_tag) == n) begin
                c_d[n*PW +: PW] = mult_c_i;
                valid_d[n]      = 1'b1;
                done_d[n]       = 1'b1;
            end
        end

        vld_d[0] = gnt_vld;
        tag_d[0] = gnt_idx;
        for (int i = 1; i < MULT_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        busy_d = |vld_d;
        for (int n = 0; n < NUM_CH; n++) begin
            if (state_d[n] == CH_PEND) busy_d = 1'b1;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            // NOTE: operand and tag arrays are reset too, so no stale tag can
            // produce a done_o after reset is released.
            for (int n = 0; n < NUM_CH; n++) state_q[n] <= CH_IDLE;
            for (int i = 0; i < MULT_LAT; i++) tag_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= '0;
            c_q     <= '0;
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vld_q   <= vld_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign c_o     = c_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched: directed stimulus pushes expected
// issues/results into queues; monitors pop and compare on each DUT event.
module tb_mult_share_sched;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int PW     = 32;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            cyc;
    } iss_t;

    typedef struct {
        int            ch;
        logic [PW-1:0] c;
        int            cyc;
    } res_t;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic [NUM_CH-1:0]      req;
    logic [NUM_CH*DW-1:0]   a_in;
    logic [NUM_CH*DW-1:0]   b_in;
    logic [NUM_CH-1:0]      clr;
    logic [DW-1:0]          mult_a;
    logic [DW-1:0]          mult_b;
    logic                   mult_issue;
    logic [PW-1:0]          mult_c;
    logic [NUM_CH*PW-1:0]   c_out;
    logic [NUM_CH-1:0]      valid;
    logic [NUM_CH-1:0]      done;
    logic [NUM_CH-1:0]      err;
    logic                   busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    iss_t iss_q[$];
    res_t res_q[$];
    iss_t ie;
    res_t re;
    logic [PW-1:0] mp0, mp1;

    mult_share_sched dut (
        .WBs_CLK_i    (clk),
        .WBs_RST_i    (rst_n),
        .enable_i     (enable),
        .req_i        (req),
        .a_i          (a_in),
        .b_i          (b_in),
        .clr_i        (clr),
        .mult_a_o     (mult_a),
        .mult_b_o     (mult_b),
        .mult_issue_o (mult_issue),
        .mult_c_i     (mult_c),
        .c_o          (c_out),
        .valid_o      (valid),
        .done_o       (done),
        .err_o        (err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural two-stage multiplier standing in for the hard block.
    always @(posedge clk) begin
        mp0 <= mult_issue ? (PW'(mult_a) * PW'(mult_b)) : '0;
        mp1 <= mp0;
    end
    assign mult_c = mp1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || res_q.size() != 0) && k < budget) begin
            step(1);
            k++;
        end
        if (k >= budget) begin
            check("idle_timeout_busy", busy, 0);
            check("idle_timeout_pending", res_q.size(), 0);
        end
        step(1);
    endtask

    task automatic set_ops(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_in[ch*DW +: DW] = a;
        b_in[ch*DW +: DW] = b;
    endtask

    task automatic exp_issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input int c);
        iss_t e;
        e.a = a; e.b = b; e.cyc = c;
        iss_q.push_back(e);
    endtask

    task automatic exp_res(input int ch, input logic [PW-1:0] v, input int c);
        res_t e;
        e.ch = ch; e.c = v; e.cyc = c;
        res_q.push_back(e);
    endtask

    // Monitor: compares every issue and every done pulse against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mult_issue) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", mult_issue, 0);
                end else begin
                    ie = iss_q.pop_front();
                    check("issue_a", mult_a, ie.a);
                    check("issue_b", mult_b, ie.b);
                    check("issue_cycle", cyc, ie.cyc);
                end
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (done[n]) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", done[n], 0);
                    end else begin
                        re = res_q.pop_front();
                        check("done_channel", n, re.ch);
                        check("result_c", c_out[n*PW +: PW], re.c);
                        check("result_valid", valid[n], 1);
                        check("done_cycle", cyc, re.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t;
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = '0;
        clr    = '0;
        a_in   = '0;
        b_in   = '0;
        step(3);
        check("rst_c",     c_out, 0);
        check("rst_valid", valid, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_busy",  busy, 0);
        check("rst_issue", mult_issue, 0);
        rst_n = 1'b1;
        step(2);

        // All four channels at once: issue order 0..3, one per cycle.
        t = cyc;
        for (int n = 0; n < NUM_CH; n++) begin
            set_ops(n, 16'(n + 1), 16'h0100);
            exp_issue(16'(n + 1), 16'h0100, t + 1 + n);
        end
        exp_res(0, 32'h0000_0100, t + 4);
        exp_res(1, 32'h0000_0200, t + 5);
        exp_res(2, 32'h0000_0300, t + 6);
        exp_res(3, 32'h0000_0400, t + 7);
        req = 4'b1111;
        step(1);
        req = '0;
        wait_idle(20);

        // Single operation on ch0.
        t = cyc;
        set_ops(0, 16'h1234, 16'h0010);
        exp_issue(16'h1234, 16'h0010, t + 1);
        exp_res(0, 32'h0001_2340, t + 4);
        req = 4'b0001;
        step(1);
        req = '0;
        check("busy_after_req", busy, 1);
        wait_idle(20);
        check("single_c0", c_out[31:0], 32'h0001_2340);
        check("single_valid0", valid[0], 1);

        // Fairness: grant ch2, then ch1+ch3 together -> ch3 before ch1.
        t = cyc;
        set_ops(2, 16'h0002, 16'h0003);
        exp_issue(16'h0002, 16'h0003, t + 1);
        exp_res(2, 32'h0000_0006, t + 4);
        req = 4'b0100;
        step(1);
        req = '0;
        step(1);
        set_ops(1, 16'h8000, 16'h0002);
        set_ops(3, 16'hFFFF, 16'hFFFF);
        exp_issue(16'hFFFF, 16'hFFFF, t + 3);
        exp_issue(16'h8000, 16'h0002, t + 4);
        exp_res(3, 32'hFFFE_0001, t + 6);
        exp_res(1, 32'h0001_0000, t + 7);
        req = 4'b1010;
        step(1);
        req = '0;
        wait_idle(20);

        // Overflow on ch1: second request dropped, err set, operands kept.
        t = cyc;
        set_ops(1, 16'h0003, 16'h0005);
        exp_issue(16'h0003, 16'h0005, t + 1);
        exp_res(1, 32'h0000_000F, t + 4);
        req = 4'b0010;
        step(1);
        set_ops(1, 16'h0007, 16'h0007);
        step(1);
        req = '0;
        check("ovf_err1", err[1], 1);
        wait_idle(20);
        check("ovf_c1", c_out[1*PW +: PW], 32'h0000_000F);
        check("ovf_valid1", valid[1], 1);
        clr = 4'b0010;
        step(1);
        clr = '0;
        check("clr_valid1", valid[1], 0);
        check("clr_err1", err[1], 0);

        // clr on ch2 in its write cycle: valid wins, err still cleared.
        t = cyc;
        set_ops(2, 16'h00FF, 16'h0101);
        exp_issue(16'h00FF, 16'h0101, t + 1);
        exp_res(2, 32'h0000_FFFF, t + 4);
        req = 4'b0100;
        step(1);
        set_ops(2, 16'h0009, 16'h0009);
        step(1);
        req = '0;
        check("clr_race_err_set", err[2], 1);
        step(1);
        clr = 4'b0100;
        step(1);
        clr = '0;
        check("clr_race_valid2", valid[2], 1);
        check("clr_race_err2", err[2], 0);
        wait_idle(20);

        // enable low: ch0 stays pending; issue follows enable in the same cycle.
        enable = 1'b0;
        set_ops(0, 16'h0005, 16'h0007);
        req = 4'b0001;
        step(1);
        req = '0;
        step(4);
        check("hold_busy", busy, 1);
        check("hold_no_issue", mult_issue, 0);
        t = cyc;
        exp_issue(16'h0005, 16'h0007, t);
        exp_res(0, 32'h0000_0023, t + 3);
        enable = 1'b1;
        wait_idle(20);

        // Reset with ch0 in flight: everything clears, no late done.
        t = cyc;
        set_ops(0, 16'h4321, 16'h0002);
        exp_issue(16'h4321, 16'h0002, t + 1);
        req = 4'b0001;
        step(1);
        req = '0;
        step(1);
        rst_n = 1'b0;
        #1;
        check("midrst_c",     c_out, 0);
        check("midrst_valid", valid, 0);
        check("midrst_done",  done, 0);
        check("midrst_err",   err, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_issue", mult_issue, 0);
        step(2);
        rst_n = 1'b1;
        step(6);
        check("postrst_busy",  busy, 0);
        check("postrst_valid", valid, 0);

        check("issue_queue_drained", iss_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
